// File: rtl/commutation_pkg.sv
// commutation_pkg: shared state codes and widths for the commutation sequencer
package commutation_pkg;
   localparam int         K_STEP_W     = 3;
   localparam logic [2:0] K_IDLE_CODE  = 3'd0;
   localparam logic [2:0] K_BRAKE_CODE = 3'd4;
   localparam logic [2:0] K_FAULT_CODE = 3'd5;
   typedef enum logic [2:0] {
      ST_IDLE  = K_IDLE_CODE,
      ST_ALIGN = 3'd1,
      ST_RAMP  = 3'd2,
      ST_RUN   = 3'd3,
      ST_BRAKE = K_BRAKE_CODE,
      ST_FAULT = K_FAULT_CODE
   } state_e;
endpackage

// File: rtl/step_rate_timer.sv
// step_rate_timer: substep period counter plus substep-in-step counter
// Ports: i_enable counts, i_clear zeroes both counters, i_period is the substep period (0 acts as 1);
//        o_substep flags the last clk of a period, o_full_step flags the last substep of an electrical step.
module step_rate_timer #(
   parameter int K_PERIOD_W  = 16,
   parameter int K_NSUBSTEPS = 10
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_enable,
   input  logic                  i_clear,
   input  logic [K_PERIOD_W-1:0] i_period,
   output logic                  o_substep,
   output logic                  o_full_step
);
   localparam int K_SUB_W = $clog2(K_NSUBSTEPS);
   logic [K_PERIOD_W-1:0] cnt_q, cnt_d, last;
   logic [K_SUB_W-1:0]    sub_q, sub_d;
   always_comb begin
      last        = (i_period == '0) ? '0 : i_period - 1'b1;
      // >= keeps the counter from running away if the period shrinks below it
      o_substep   = i_enable && (cnt_q >= last);
      o_full_step = o_substep && (sub_q >= K_SUB_W'(K_NSUBSTEPS - 1));
      cnt_d       = i_clear ? '0 : !i_enable ? cnt_q : o_substep ? '0 : cnt_q + 1'b1;
      sub_d       = i_clear ? '0 : o_full_step ? '0 : o_substep ? sub_q + 1'b1 : sub_q;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_q <= '0;
         sub_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         sub_q <= sub_d;
      end
   end
endmodule

// File: rtl/commutation_sequencer.sv
// commutation_sequencer: open-loop align/ramp/run/brake sequencer for the 6-step pattern generator
// Optional feature: define COMMUTATION_POWER_RAMP_EN to ramp o_power up during RAMP.
// Ports: i_start/i_stop/i_fault drive the FSM; i_align_*, i_period_*, i_brake_time set timing;
//        o_force_* align the rotor, o_step_trigger/o_step_reverse step it, o_brake/o_power set drive,
//        o_state/o_running report status. All outputs are registered.
module commutation_sequencer
   import commutation_pkg::*;
#(
   parameter int K_NSUBSTEPS = 10,
   parameter int K_PERIOD_W  = 16,
   parameter int K_ALIGN_W   = 20
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_start,
   input  logic                           i_stop,
   input  logic                           i_fault,
   input  logic                           i_direction,
   input  logic [2:0]                     i_align_step,
   input  logic [K_ALIGN_W-1:0]           i_align_time,
   input  logic [K_PERIOD_W-1:0]          i_period_start,
   input  logic [K_PERIOD_W-1:0]          i_period_min,
   input  logic [K_PERIOD_W-1:0]          i_period_dec,
   input  logic [K_PERIOD_W-1:0]          i_brake_time,
   input  logic [$clog2(K_NSUBSTEPS)-1:0] i_power_target,
   output logic [2:0]                     o_force_step_value,
   output logic                           o_force_step_trigger,
   output logic [$clog2(K_NSUBSTEPS)-1:0] o_force_substep,
   output logic                           o_step_trigger,
   output logic                           o_step_reverse,
   output logic                           o_brake,
   output logic                           o_bypass_power,
   output logic [$clog2(K_NSUBSTEPS)-1:0] o_power,
   output logic [2:0]                     o_state,
   output logic                           o_running
);
   localparam int K_SUB_W = $clog2(K_NSUBSTEPS);
   localparam int K_DW    = (K_ALIGN_W > K_PERIOD_W) ? K_ALIGN_W : K_PERIOD_W;
   state_e                state_q, state_d;
   logic [K_DW-1:0]       dwell_q, dwell_d, align_lim, brake_lim;
   logic [K_PERIOD_W-1:0] period_q, period_d, dec_period, ramp_period;
   logic [K_SUB_W-1:0]    power_q, power_d, ramp_power, align_power;
   logic [K_STEP_W-1:0]   force_val_q, force_val_d;
   logic                  force_trig_q, force_trig_d, trig_q, trig_d, rev_q, rev_d;
   logic                  brake_q, brake_d, running_q, running_d;
   logic                  timing, entering_align, substep, full_step;

   assign timing = (state_q == ST_RAMP) || (state_q == ST_RUN);

   step_rate_timer #(.K_PERIOD_W(K_PERIOD_W), .K_NSUBSTEPS(K_NSUBSTEPS)) u_timer (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_enable    (timing),
      .i_clear     (!timing),
      .i_period    (period_q),
      .o_substep   (substep),
      .o_full_step (full_step)
   );

   always_comb begin
      align_lim   = (i_align_time == '0) ? '0 : K_DW'(i_align_time - 1'b1);
      brake_lim   = (i_brake_time == '0) ? '0 : K_DW'(i_brake_time - 1'b1);
      dec_period  = (period_q > i_period_dec) ? period_q - i_period_dec : '0;
      ramp_period = (dec_period > i_period_min) ? dec_period : i_period_min;
      state_d     = state_q;
      if (i_fault)
         state_d = ST_FAULT;
      else if (i_stop && (state_q inside {ST_ALIGN, ST_RAMP, ST_RUN}))
         state_d = ST_BRAKE;
      else begin
         case (state_q)
            ST_IDLE:  state_d = (i_start && !i_stop) ? ST_ALIGN : ST_IDLE;
            ST_ALIGN: if (dwell_q >= align_lim) state_d = (i_period_start <= i_period_min) ? ST_RUN : ST_RAMP;
            ST_RAMP:  if (full_step && (ramp_period == i_period_min)) state_d = ST_RUN;
            ST_RUN:   state_d = ST_RUN;
            ST_BRAKE: if (dwell_q >= brake_lim) state_d = ST_IDLE;
            ST_FAULT: if (!i_start) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
      entering_align = (state_q == ST_IDLE) && (state_d == ST_ALIGN);
      // one dwell counter serves both ALIGN and BRAKE; it restarts on every state change
      dwell_d      = (state_d != state_q) ? '0 : dwell_q + 1'b1;
      period_d     = ((state_q == ST_ALIGN) && (state_d inside {ST_RAMP, ST_RUN}))
                        ? ((i_period_start <= i_period_min) ? i_period_min : i_period_start)
                   : ((state_q == ST_RAMP) && full_step) ? ramp_period
                   : ((state_q == ST_RUN) && substep) ? i_period_min
                   : period_q;
      force_trig_d = entering_align;
      force_val_d  = entering_align ? ((i_align_step > 3'd5) ? '0 : i_align_step) : force_val_q;
      rev_d        = entering_align ? i_direction : rev_q;
      trig_d       = substep && (state_d inside {ST_RAMP, ST_RUN});
      brake_d      = state_d inside {ST_BRAKE, ST_FAULT};
      running_d    = state_d == ST_RUN;
`ifdef COMMUTATION_POWER_RAMP_EN
      align_power  = (i_power_target == '0) ? '0 : K_SUB_W'(1);
      ramp_power   = (state_q != ST_RAMP) ? align_power
                   : (full_step && (power_q < i_power_target)) ? power_q + 1'b1
                   : (power_q > i_power_target) ? i_power_target
                   : power_q;
`else
      align_power  = i_power_target;
      ramp_power   = i_power_target;
`endif
      power_d      = (state_d == ST_ALIGN) ? align_power
                   : (state_d == ST_RAMP) ? ramp_power
                   : (state_d == ST_RUN) ? i_power_target
                   : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= ST_IDLE;
         dwell_q      <= '0;
         period_q     <= '0;
         power_q      <= '0;
         force_val_q  <= '0;
         force_trig_q <= 1'b0;
         trig_q       <= 1'b0;
         rev_q        <= 1'b0;
         brake_q      <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         dwell_q      <= dwell_d;
         period_q     <= period_d;
         power_q      <= power_d;
         force_val_q  <= force_val_d;
         force_trig_q <= force_trig_d;
         trig_q       <= trig_d;
         rev_q        <= rev_d;
         brake_q      <= brake_d;
         running_q    <= running_d;
      end
   end

   assign o_force_step_value   = force_val_q;
   assign o_force_step_trigger = force_trig_q;
   assign o_force_substep      = '0;
   assign o_step_trigger       = trig_q;
   assign o_step_reverse       = rev_q;
   assign o_brake              = brake_q;
   assign o_bypass_power       = 1'b0;
   assign o_power              = power_q;
   assign o_state              = state_q;
   assign o_running            = running_q;
endmodule
